uart_mem_loader: RTL and testbench

UART_MEM_LOADER -- requirements
Module: uart_mem_loader

---
 rtl/uart_mem_loader_if.sv | 37 +++
 rtl/uart_mem_loader.sv | 207 ++++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_loader_if.sv
// -----------------------------------------------------------------------------
// uart_mem_loader_if
// Groups the byte streams and the memory write port of the UART memory loader.
//
// Signals:
//   rx_tdata_i / rx_tvalid_i / rx_tready_o : received byte stream (UART -> loader)
//   tx_tdata_o / tx_tvalid_o / tx_tready_i : response byte stream (loader -> UART)
//   ram_we_o / ram_addr_o / ram_wdata_o / ram_wstrb_o : one-cycle word write port
//
// Modports:
//   master : the loader itself (consumes rx, produces tx and memory writes)
//   slave  : the environment (UART core and memory)
// -----------------------------------------------------------------------------
interface uart_mem_loader_if;
   logic [7:0]  rx_tdata_i;
   logic        rx_tvalid_i;
   logic        rx_tready_o;
   logic [7:0]  tx_tdata_o;
   logic        tx_tvalid_o;
   logic        tx_tready_i;
   logic        ram_we_o;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_wdata_o;
   logic [3:0]  ram_wstrb_o;

   modport master (
      input  rx_tdata_i, rx_tvalid_i, tx_tready_i,
      output rx_tready_o, tx_tdata_o, tx_tvalid_o,
             ram_we_o, ram_addr_o, ram_wdata_o, ram_wstrb_o
   );

   modport slave (
      output rx_tdata_i, rx_tvalid_i, tx_tready_i,
      input  rx_tready_o, tx_tdata_o, tx_tvalid_o,
             ram_we_o, ram_addr_o, ram_wdata_o, ram_wstrb_o
   );
endinterface

// File: rtl/uart_mem_loader.sv
// -----------------------------------------------------------------------------
// uart_mem_loader
// Receives write packets over a byte stream and turns them into 32-bit memory
// writes, answering each packet with a single ACK or NAK byte.
//
// Packet: CmdWrite, 4 address bytes (LE), 2 word-count bytes (LE),
//         N x 4 data bytes (LE), [checksum byte].
//
// Ports:
//   clk_i    : clock, rising edge
//   reset_i  : synchronous active-high reset
//   bus      : uart_mem_loader_if.master (rx stream, tx stream, memory port)
//   busy_o   : high whenever the loader is not idle
//
// Build option:
//   UART_LOADER_CHECKSUM_EN : when defined, a trailing checksum byte (mod-256
//   sum of all data bytes) follows the data and selects ACK or NAK.
//   When undefined, the packet ends after the last data word (or N==0) with ACK.
// -----------------------------------------------------------------------------
module uart_mem_loader #(
   parameter logic [7:0] CmdWrite = 8'h57,
   parameter logic [7:0] AckByte  = 8'h06,
   parameter logic [7:0] NakByte  = 8'h15
) (
   input  logic              clk_i,
   input  logic              reset_i,
   uart_mem_loader_if.master bus,
   output logic              busy_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      LEN   = 3'd2,
      DATA  = 3'd3,
      WRITE = 3'd4,
`ifdef UART_LOADER_CHECKSUM_EN
      CSUM  = 3'd5,
`endif
      RESP  = 3'd6
   } state_t;

   // State entered once all words of a packet have been written.
`ifdef UART_LOADER_CHECKSUM_EN
   localparam state_t DoneState = CSUM;
`else
   localparam state_t DoneState = RESP;
`endif

   state_t      state_q, state_d;
   logic [7:0]  resp_q, resp_d;
   logic [1:0]  byte_cnt_q;
   logic        len_cnt_q;
   logic [31:0] addr_q;
   logic [15:0] len_q;
   logic [31:0] word_q;
`ifdef UART_LOADER_CHECKSUM_EN
   logic [7:0]  sum_q;
`endif

   logic rx_ready;
   logic rx_fire;

   // The loader only stalls the receiver while writing or answering.
   assign rx_ready = (state_q != WRITE) && (state_q != RESP);
   assign rx_fire  = rx_ready && bus.rx_tvalid_i;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------- next state / outputs
   always_comb begin
      state_d = state_q;
      resp_d  = resp_q;
      case (state_q)
         IDLE: begin
            if (bus.rx_tvalid_i) begin
               if (bus.rx_tdata_i == CmdWrite) begin
                  state_d = ADDR;
               end else begin
                  state_d = RESP;
                  resp_d  = NakByte;
               end
            end
         end
         ADDR: begin
            if (bus.rx_tvalid_i && byte_cnt_q == 2'd3) begin
               state_d = LEN;
            end
         end
         LEN: begin
            if (bus.rx_tvalid_i && len_cnt_q) begin
               if ({bus.rx_tdata_i, len_q[7:0]} == 16'd0) begin
                  state_d = DoneState;
                  resp_d  = AckByte;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (bus.rx_tvalid_i && byte_cnt_q == 2'd3) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (len_q == 16'd1) begin
               state_d = DoneState;
               resp_d  = AckByte;
            end else begin
               state_d = DATA;
            end
         end
`ifdef UART_LOADER_CHECKSUM_EN
         CSUM: begin
            if (bus.rx_tvalid_i) begin
               state_d = RESP;
               resp_d  = (bus.rx_tdata_i == sum_q) ? AckByte : NakByte;
            end
         end
`endif
         RESP: begin
            if (bus.tx_tready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         resp_q     <= 8'h00;
         byte_cnt_q <= 2'd0;
         len_cnt_q  <= 1'b0;
         addr_q     <= 32'd0;
         len_q      <= 16'd0;
         word_q     <= 32'd0;
`ifdef UART_LOADER_CHECKSUM_EN
         sum_q      <= 8'h00;
`endif
      end else begin
         resp_q <= resp_d;
         case (state_q)
            IDLE: begin
               if (rx_fire) begin
                  byte_cnt_q <= 2'd0;
                  len_cnt_q  <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
                  sum_q      <= 8'h00;
`endif
               end
            end
            ADDR: begin
               if (rx_fire) begin
                  addr_q[{byte_cnt_q, 3'b000} +: 8] <= bus.rx_tdata_i;
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  // Later assignment wins: keep the address word-aligned.
                  addr_q[1:0] <= 2'b00;
               end
            end
            LEN: begin
               if (rx_fire) begin
                  len_q[{len_cnt_q, 3'b000} +: 8] <= bus.rx_tdata_i;
                  len_cnt_q <= ~len_cnt_q;
               end
            end
            DATA: begin
               if (rx_fire) begin
                  word_q[{byte_cnt_q, 3'b000} +: 8] <= bus.rx_tdata_i;
                  // Wraps to 0 after the 4th byte, ready for the next word.
                  byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                  sum_q      <= sum_q + bus.rx_tdata_i;
`endif
               end
            end
            WRITE: begin
               addr_q <= addr_q + 32'd4;
               len_q  <= len_q - 16'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------ outputs
   assign bus.rx_tready_o = rx_ready;
   assign bus.tx_tvalid_o = (state_q == RESP);
   assign bus.tx_tdata_o  = (state_q == RESP) ? resp_q : 8'h00;
   assign bus.ram_we_o    = (state_q == WRITE);
   assign bus.ram_addr_o  = addr_q;
   assign bus.ram_wdata_o = word_q;
   assign bus.ram_wstrb_o = (state_q == WRITE) ? 4'hF : 4'h0;
   assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_mem_loader
// Directed testbench for uart_mem_loader. Drives packets on the rx stream,
// collects memory writes and tx bytes in queues and compares them with
// hand-computed values. Works with or without UART_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_uart_mem_loader;

   logic clk_i;
   logic reset_i;
   logic busy_o;

   uart_mem_loader_if bus ();

   uart_mem_loader dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus.master),
      .busy_o  (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   logic [3:0]  ws_q[$];
   logic [7:0]  tx_q[$];
   logic [7:0]  dbytes[16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Collect memory writes and completed tx handshakes.
   always @(negedge clk_i) begin
      if (reset_i === 1'b0) begin
         if (bus.ram_we_o === 1'b1) begin
            wa_q.push_back(bus.ram_addr_o);
            wd_q.push_back(bus.ram_wdata_o);
            ws_q.push_back(bus.ram_wstrb_o);
         end
         if (bus.tx_tvalid_o === 1'b1 && bus.tx_tready_i === 1'b1) begin
            tx_q.push_back(bus.tx_tdata_o);
         end
      end
   end

   // Drive one rx byte after 'gap' idle cycles; returns at posedge+1 after the handshake.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit done;
      int waited;
      repeat (gap) begin
         @(posedge clk_i);
         #1;
      end
      bus.rx_tdata_i  = b;
      bus.rx_tvalid_i = 1'b1;
      done   = 1'b0;
      waited = 0;
      while (!done) begin
         @(negedge clk_i);
         done = bus.rx_tready_o;
         @(posedge clk_i);
         #1;
         waited++;
         if (!done && waited > 50) begin
            check("rx_accept_timeout", 32'd0, 32'd1);
            done = 1'b1;
         end
      end
      bus.rx_tvalid_i = 1'b0;
      bus.rx_tdata_i  = 8'hA5;
   endtask

   task automatic send_pkt(input logic [31:0] addr, input int nwords, input int gap);
`ifdef UART_LOADER_CHECKSUM_EN
      logic [7:0] sum;
      sum = 8'h00;
`endif
      send_byte(8'h57, gap);
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], gap);
      send_byte(nwords[7:0], gap);
      send_byte(nwords[15:8], gap);
      for (int i = 0; i < 4 * nwords; i++) begin
         send_byte(dbytes[i], gap);
`ifdef UART_LOADER_CHECKSUM_EN
         sum = sum + dbytes[i];
`endif
      end
`ifdef UART_LOADER_CHECKSUM_EN
      send_byte(sum, gap);
`endif
   endtask

   task automatic expect_write(input string tag, input logic [31:0] a, input logic [31:0] d);
      check({tag, "_present"}, 32'(wa_q.size() > 0), 32'd1);
      if (wa_q.size() > 0) begin
         check({tag, "_addr"}, wa_q.pop_front(), a);
         check({tag, "_data"}, wd_q.pop_front(), d);
         check({tag, "_wstrb"}, 32'(ws_q.pop_front()), 32'hF);
      end
   endtask

   task automatic expect_resp(input string tag, input logic [7:0] exp);
      int w;
      w = 0;
      while (tx_q.size() == 0 && w < 100) begin
         @(negedge clk_i);
         w++;
      end
      check({tag, "_seen"}, 32'(tx_q.size() != 0), 32'd1);
      if (tx_q.size() != 0) check({tag, "_byte"}, 32'(tx_q.pop_front()), 32'(exp));
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_data();
      foreach (dbytes[i]) dbytes[i] = 8'h00;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      reset_i         = 1'b1;
      bus.rx_tdata_i  = 8'h00;
      bus.rx_tvalid_i = 1'b0;
      bus.tx_tready_i = 1'b1;
      clear_data();

      // Reset state
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check("rst_busy",    32'(busy_o), 32'd0);
      check("rst_rxready", 32'(bus.rx_tready_o), 32'd1);
      check("rst_txvalid", 32'(bus.tx_tvalid_o), 32'd0);
      check("rst_txdata",  32'(bus.tx_tdata_o), 32'd0);
      check("rst_we",      32'(bus.ram_we_o), 32'd0);
      check("rst_addr",    bus.ram_addr_o, 32'd0);
      check("rst_wdata",   bus.ram_wdata_o, 32'd0);
      check("rst_wstrb",   32'(bus.ram_wstrb_o), 32'd0);
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;

      // Single word packet with write-strobe timing
      send_byte(8'h57, 0);
      send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0);
      check("p1_busy", 32'(busy_o), 32'd1);
      send_byte(8'hDE, 0);
      @(negedge clk_i);
      check("p1_we_timing",   32'(bus.ram_we_o), 32'd1);
      check("p1_rxready_low", 32'(bus.rx_tready_o), 32'd0);
      @(negedge clk_i);
      check("p1_we_one_cycle", 32'(bus.ram_we_o), 32'd0);
`ifdef UART_LOADER_CHECKSUM_EN
      @(posedge clk_i);
      #1;
      send_byte(8'hEF + 8'hBE + 8'hAD + 8'hDE, 0);
`endif
      expect_resp("p1", 8'h06);
      expect_write("p1_w0", 32'h0000_1000, 32'hDEAD_BEEF);
      check("p1_nwrites", 32'(wa_q.size()), 32'd0);

      // Two words, unaligned address bytes, gaps between bytes
      clear_data();
      for (int i = 0; i < 8; i++) dbytes[i] = 8'(i + 1);
      send_pkt(32'h0000_0003, 2, 3);
      expect_resp("p2", 8'h06);
      expect_write("p2_w0", 32'h0000_0000, 32'h0403_0201);
      expect_write("p2_w1", 32'h0000_0004, 32'h0807_0605);
      check("p2_nwrites", 32'(wa_q.size()), 32'd0);

      // Bad command byte
      send_byte(8'h41, 0);
      expect_resp("p3", 8'h15);
      @(negedge clk_i);
      check("p3_busy_after", 32'(busy_o), 32'd0);
      check("p3_nwrites", 32'(wa_q.size()), 32'd0);
      @(posedge clk_i);
      #1;

      // Address wrap
      clear_data();
      for (int i = 0; i < 8; i++) dbytes[i] = 8'((i + 1) * 17);
      send_pkt(32'hFFFF_FFFC, 2, 0);
      expect_resp("p4", 8'h06);
      expect_write("p4_w0", 32'hFFFF_FFFC, 32'h4433_2211);
      expect_write("p4_w1", 32'h0000_0000, 32'h8877_6655);
      check("p4_nwrites", 32'(wa_q.size()), 32'd0);

      // Zero-length packet
      send_pkt(32'h0000_2000, 0, 1);
      expect_resp("p5", 8'h06);
      check("p5_nwrites", 32'(wa_q.size()), 32'd0);

`ifdef UART_LOADER_CHECKSUM_EN
      // Checksum match and mismatch
      send_byte(8'h57, 0);
      for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
      send_byte(8'h0A, 0);
      expect_resp("cs_ok", 8'h06);
      expect_write("cs_ok_w0", 32'h0000_0000, 32'h0403_0201);
      send_byte(8'h57, 0);
      for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
      send_byte(8'h0B, 0);
      expect_resp("cs_bad", 8'h15);
      expect_write("cs_bad_w0", 32'h0000_0000, 32'h0403_0201);
`endif

      // Reset mid-packet, then a clean packet with a stalled response
      send_byte(8'h57, 0);
      send_byte(8'h00, 0); send_byte(8'h30, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'hAA, 0); send_byte(8'hBB, 0);
      reset_i = 1'b1;
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_nwrites", 32'(wa_q.size()), 32'd0);
      check("abort_ntx", 32'(tx_q.size()), 32'd0);
      @(posedge clk_i);
      #1;

      bus.tx_tready_i = 1'b0;
      clear_data();
      for (int i = 0; i < 4; i++) dbytes[i] = 8'(i + 1);
      send_pkt(32'h0000_2000, 1, 0);
      w = 0;
      while (bus.tx_tvalid_o !== 1'b1 && w < 20) begin
         @(negedge clk_i);
         w++;
      end
      check("stall_valid_seen", 32'(bus.tx_tvalid_o), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         check("stall_txvalid", 32'(bus.tx_tvalid_o), 32'd1);
         check("stall_txdata",  32'(bus.tx_tdata_o), 32'h06);
      end
      @(posedge clk_i);
      #1;
      bus.tx_tready_i = 1'b1;
      expect_resp("p6", 8'h06);
      expect_write("p6_w0", 32'h0000_2000, 32'h0403_0201);
      check("p6_nwrites", 32'(wa_q.size()), 32'd0);
      @(negedge clk_i);
      check("p6_busy_after", 32'(busy_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
